// File: rtl/clint_mmio.sv
// Core-local interruptor: per-hart msip/mtimecmp, one shared 64-bit mtime, a
// valid/ready request/response port with backpressure, and a selectable time base.
module clint_mmio #(
  parameter int unsigned           HART_NUM  = 1,
  parameter int unsigned           ADDR_BIT  = 32,
  parameter logic [ADDR_BIT-1:0]   BASE_ADDR = ADDR_BIT'(32'h0200_0000),
  parameter int unsigned           TICK_SRC  = 0,
  parameter int unsigned           TICK_DIV  = 100
) (
  input  logic                 clk_sys_i,
  input  logic                 rst_n_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_wea_i,
  input  logic [ADDR_BIT-1:0]  req_addr_i,
  input  logic [2:0]           req_width_i,
  input  logic [63:0]          req_wdata_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [63:0]          rsp_rdata_o,
  output logic                 rsp_err_o,
  output logic                 hit_o,
  input  logic                 rtc_i,
  output logic [HART_NUM-1:0]  time_intr_o,
  output logic [HART_NUM-1:0]  software_intr_o
);

  localparam int unsigned DIV_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [12:0] MTIME_WORD = 13'h17FF;  // 0xBFF8 >> 3

  typedef enum logic {ST_IDLE = 1'b0, ST_RESP = 1'b1} state_t;
  state_t state_reg, state_next;

  logic [ADDR_BIT-1:0] offset;
  logic [15:0]         off16;
  logic [13:0]         msip_idx;
  logic [10:0]         cmp_idx;
  logic                width_ok;
  logic                aligned;
  logic                sel_mtime;
  logic                region_ok;
  logic                legal;
  logic                accept;
  logic                wr_en;
  logic                tick;
  logic [HART_NUM-1:0] msip_sel;
  logic [HART_NUM-1:0] cmp_sel;
  logic [2:0]          reg_byte;
  logic [5:0]          shift;
  logic [7:0]          byte_mask;
  logic [63:0]         data_mask;
  logic [63:0]         wr_mask;
  logic [63:0]         wr_data;
  logic [63:0]         reg_val;
  logic [63:0]         rd_data;

  logic [HART_NUM-1:0] msip_reg;
  logic [63:0]         mtimecmp_reg [HART_NUM];
  logic [63:0]         mtime_reg;
  logic [63:0]         rsp_rdata_reg;
  logic                rsp_err_reg;

  // ---------------------------------------------------------------- decode
  assign offset    = req_addr_i - BASE_ADDR;
  assign off16     = offset[15:0];
  assign hit_o     = ~|offset[ADDR_BIT-1:16];
  assign msip_idx  = off16[15:2];
  assign cmp_idx   = off16[13:3];
  assign width_ok  = (req_width_i == 3'd0) || (req_width_i == 3'd1) ||
                     (req_width_i == 3'd3) || (req_width_i == 3'd7);
  assign aligned   = (off16[2:0] & req_width_i) == 3'b000;
  assign sel_mtime = (off16[15:3] == MTIME_WORD);
  assign region_ok = (|msip_sel) || (|cmp_sel) || sel_mtime;
  assign legal     = hit_o && width_ok && aligned && region_ok;

  // msip is a 32-bit register, so its byte position comes from the low two bits only
  assign reg_byte  = (|msip_sel) ? {1'b0, off16[1:0]} : off16[2:0];
  assign shift     = {reg_byte, 3'b000};

  always_comb begin
    byte_mask = 8'h00;
    case (req_width_i)
      3'd0:    byte_mask = 8'h01;
      3'd1:    byte_mask = 8'h03;
      3'd3:    byte_mask = 8'h0F;
      3'd7:    byte_mask = 8'hFF;
      default: byte_mask = 8'h00;
    endcase
  end

  always_comb begin
    data_mask = '0;
    for (int b = 0; b < 8; b++) begin
      data_mask[8*b +: 8] = {8{byte_mask[b]}};
    end
  end

  assign wr_mask = data_mask << shift;
  assign wr_data = req_wdata_i << shift;

  always_comb begin
    reg_val = '0;
    if (sel_mtime) begin
      reg_val = mtime_reg;
    end
    for (int h = 0; h < HART_NUM; h++) begin
      if (msip_sel[h]) begin
        reg_val = {63'b0, msip_reg[h]};
      end
      if (cmp_sel[h]) begin
        reg_val = mtimecmp_reg[h];
      end
    end
  end

  assign rd_data = (reg_val >> shift) & data_mask;

  // ---------------------------------------------------------------- handshake FSM
  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = ST_RESP;
      ST_RESP: if (rsp_ready_i) state_next = accept ? ST_RESP : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = 1'b1;
    rsp_valid_o = 1'b0;
    if (rst_n_i && (state_reg == ST_RESP)) begin
      rsp_valid_o = 1'b1;
      req_ready_o = rsp_ready_i;
    end
  end

  assign accept = rst_n_i && req_valid_i && req_ready_o;
  assign wr_en  = accept && req_wea_i && legal;

  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i) begin
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else if (accept) begin
      rsp_rdata_reg <= (!req_wea_i && legal) ? rd_data : 64'd0;
      rsp_err_reg   <= !legal;
    end
  end

  assign rsp_rdata_o = rsp_rdata_reg;
  assign rsp_err_o   = rsp_err_reg;

  // ---------------------------------------------------------------- time base
  generate
    if (TICK_SRC == 0) begin : g_div
      logic [DIV_W-1:0] div_reg;
      logic             unused_rtc;

      assign unused_rtc = rtc_i;
      assign tick       = (div_reg == DIV_W'(TICK_DIV - 1));

      always_ff @(posedge clk_sys_i) begin
        if (!rst_n_i) begin
          div_reg <= '0;
        end else if (tick) begin
          div_reg <= '0;
        end else begin
          div_reg <= div_reg + 1'b1;
        end
      end
    end else begin : g_rtc
      // two synchroniser flops, third flop holds the previous value for edge detect
      logic [2:0] rtc_sync_reg;

      assign tick = rtc_sync_reg[1] & ~rtc_sync_reg[2];

      always_ff @(posedge clk_sys_i) begin
        if (!rst_n_i) begin
          rtc_sync_reg <= '0;
        end else begin
          rtc_sync_reg <= {rtc_sync_reg[1:0], rtc_i};
        end
      end
    end
  endgenerate

  // A write to mtime takes priority over a coincident tick; that tick is dropped.
  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i) begin
      mtime_reg <= '0;
    end else if (wr_en && sel_mtime) begin
      mtime_reg <= (mtime_reg & ~wr_mask) | (wr_data & wr_mask);
    end else if (tick) begin
      mtime_reg <= mtime_reg + 64'd1;
    end
  end

  // ---------------------------------------------------------------- per-hart state
  generate
    for (genvar gi = 0; gi < HART_NUM; gi++) begin : g_hart
      logic        msip_bit_reg;
      logic [63:0] cmp_reg;
      logic        time_intr_reg;
      logic        software_intr_reg;

      assign msip_sel[gi] = (msip_idx == 14'(gi)) && (req_width_i != 3'd7);
      assign cmp_sel[gi]  = (off16[15:14] == 2'b01) && (cmp_idx == 11'(gi));

      always_ff @(posedge clk_sys_i) begin
        if (!rst_n_i) begin
          msip_bit_reg <= 1'b0;
        end else if (wr_en && msip_sel[gi]) begin
          msip_bit_reg <= (msip_bit_reg & ~wr_mask[0]) | (wr_data[0] & wr_mask[0]);
        end
      end

      always_ff @(posedge clk_sys_i) begin
        if (!rst_n_i) begin
          cmp_reg <= '1;
        end else if (wr_en && cmp_sel[gi]) begin
          cmp_reg <= (cmp_reg & ~wr_mask) | (wr_data & wr_mask);
        end
      end

      always_ff @(posedge clk_sys_i) begin
        if (!rst_n_i) begin
          time_intr_reg     <= 1'b0;
          software_intr_reg <= 1'b0;
        end else begin
          time_intr_reg     <= (mtime_reg >= cmp_reg);
          software_intr_reg <= msip_bit_reg;
        end
      end

      assign msip_reg[gi]        = msip_bit_reg;
      assign mtimecmp_reg[gi]    = cmp_reg;
      assign time_intr_o[gi]     = time_intr_reg;
      assign software_intr_o[gi] = software_intr_reg;
    end
  endgenerate

endmodule

// File: doc/clint_mmio.md
Name: clint_mmio

Overview:
- Standalone, parametrised core-local interruptor (CLINT), split out of the memory stage so it can serve multiple harts.
- Provides per-hart msip and mtimecmp registers, one shared 64-bit mtime, and a selectable time base (internal divider or external real-time pulse).
- Sits behind the memory stage's non-cacheable decode. The memory stage uses hit_o to steer an access here instead of to the cache.
- Uses a valid/ready request and response handshake with backpressure. Drives time_intr_o and software_intr_o to each hart's CSR unit.

Parameters:
- HART_NUM, 1: number of harts; msip and mtimecmp are replicated per hart.
- ADDR_BIT, 32: request address width.
- BASE_ADDR, 32'h0200_0000: base of the 64 KiB CLINT window.
- TICK_SRC, 0: 0 = internal divider drives mtime; 1 = rising edge of rtc_i drives mtime.
- TICK_DIV, 100: clk_sys_i cycles per mtime increment when TICK_SRC=0; must be ≥1.

Ports:
- clk_sys_i  in  1  system clock.
- rst_n_i  in  1  synchronous, active-low reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when both valid and ready are high.
- req_wea_i  in  1  1 = write, 0 = read.
- req_addr_i  in  ADDR_BIT  byte address.
- req_width_i  in  3  bytes−1; legal values are 0, 1, 3, 7.
- req_wdata_i  in  64  write data, byte-lane aligned to bit 0 (little-endian).
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed when both valid and ready are high.
- rsp_rdata_o  out  64  read data; 0 for writes.
- rsp_err_o  out  1  unmapped or misaligned access.
- hit_o  out  1  combinational: req_addr_i lies inside [BASE_ADDR, BASE_ADDR+0x10000).
- rtc_i  in  1  asynchronous real-time pulse; used only when TICK_SRC=1.
- time_intr_o  out  HART_NUM  per-hart timer interrupt.
- software_intr_o  out  HART_NUM  per-hart software interrupt.

Behaviour:
- Reset state (sampled on the clock edge while rst_n_i=0):
  - mtime = 0; every mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF; every msip = 0; divider count = 0; sync flops = 0.
  - rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0, time_intr_o = 0, software_intr_o = 0.
  - req_ready_o = 1 during and immediately after reset.
  - Reset asserted mid-transaction drops any pending response; no write is applied.
- Address map (offset = req_addr_i − BASE_ADDR):
  - msip[h] at 4·h: 32-bit register; only bit 0 is stored, all other bits read as 0.
  - mtimecmp[h] at 0x4000 + 8·h: 64-bit register.
  - mtime at 0xBFF8: 64-bit register.
  - Any other in-window offset is unmapped.
- Legality:
  - An access is legal only if it is naturally aligned and falls entirely within a single register.
  - A 64-bit access to msip is illegal.
  - A request with hit_o=0 is still accepted and returns err.
- Illegal access: writes have no effect; reads return rdata=0; err=1.
- Handshake and pipeline (two states, IDLE and RESP):
  - IDLE: req_ready_o=1. On an accepted request, decode, perform the write or capture the read data, then move to RESP on the next edge.
  - RESP: rsp_valid_o=1 and req_ready_o = rsp_ready_i.
  - If rsp_ready_i=1 and a new request is valid, that request is accepted in the same cycle (back-to-back, throughput of 1 per cycle).
  - If rsp_ready_i=1 and no new request is valid, return to IDLE.
  - If rsp_ready_i=0, rsp_rdata_o and rsp_err_o hold stable.
  - Read latency: 1 cycle from acceptance to rsp_valid_o.
  - Read data is the register value before any same-cycle update, with the addressed bytes shifted to bit 0.
- Partial writes: only bytes [off, off+width] are updated; the other bytes are kept.
- Time base:
  - TICK_SRC=0: divider counts 0 .. TICK_DIV−1 and produces a one-cycle tick on wrap.
  - TICK_SRC=1: rtc_i passes through a 2-flop synchroniser plus a third flop; tick = rising-edge detect on the synchronised signal. rtc_i-to-tick latency is 3 cycles.
  - On a tick, mtime increments by 1 and wraps modulo 2^64.
- Simultaneous mtime write and tick: the write wins. Written bytes take the write data; unwritten bytes keep their old value, with no increment applied that cycle. That tick is lost.
- Interrupt outputs (registered, 1 cycle after the state change):
  - time_intr_o[h] <= (mtime ≥ mtimecmp[h]), compared as unsigned.
  - software_intr_o[h] <= msip[h].
- Writing mtimecmp above mtime deasserts time_intr_o[h] one cycle after the write edge.

Test Plan:
1. Reset, then read mtimecmp[0] (width 7) → rsp 1 cycle later with rdata = 64'hFFFF_FFFF_FFFF_FFFF, err=0; time_intr_o=0.
2. TICK_SRC=0, TICK_DIV=4: idle 40 cycles after reset → read of mtime returns 10. Write mtimecmp[0]=12 → time_intr_o[0] rises 1 cycle after mtime reaches 12. Write mtimecmp[0]=100 → time_intr_o[0] falls.
3. HART_NUM=2: write 32'h1 to offset 0x4, then 32'h0 → software_intr_o = 2'b10, then 2'b00, each 1 cycle after the write edge; software_intr_o[0] stays 0 throughout.
4. Byte write 8'hAB at offset 0xBFFA coinciding with a tick, with mtime = 64'h0000_0000_0000_00FF → mtime = 64'h0000_0000_00AB_00FF, no increment applied.
5. Back-to-back reads with rsp_ready_i held low for 3 cycles → rsp_valid_o and rdata hold stable and req_ready_o=0. Release → second response follows on the next cycle.
6. Width 3 at offset 0x4004 → err=0. Width 3 at 0x4002 → err=1, no write. Width 7 to msip → err=1. Offset 0x8000 → rdata=0, err=1. hit_o=0 address → err=1.
